// File: rtl/sub_pipe.sv
// sub_pipe: elastic STAGES-deep pipeline computing exact (optionally absolute) a-b with borrow.
module sub_pipe #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] aIn,
    input  logic [WIDTH-1:0] bIn,
    input  logic             abs_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   subOut,
    output logic             borrow
);
    logic [STAGES-1:0] v, ld, bw, up_v, up_b;
    logic [WIDTH:0]    r    [STAGES];
    logic [WIDTH:0]    up_r [STAGES];
    logic [WIDTH:0]    diff, res;
    logic              lt, acc;
    // A stage may load when any stage from it to the output is empty or the output drains.
    always_comb begin
        lt      = aIn < bIn;
        diff    = {1'b0, aIn} - {1'b0, bIn};
        res     = (abs_mode && lt) ? -diff : diff;
        up_v[0] = in_valid;
        up_r[0] = res;
        up_b[0] = lt;
        for (int i = 1; i < STAGES; i++) begin
            up_v[i] = v[i-1];
            up_r[i] = r[i-1];
            up_b[i] = bw[i-1];
        end
        acc = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            acc   = acc | !v[i];
            ld[i] = acc;
        end
    end
    // Payload only changes when real data arrives, so outputs hold through bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            v  <= '0;
            bw <= '0;
            for (int i = 0; i < STAGES; i++) r[i] <= '0;
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (ld[i]) begin
                    v[i] <= up_v[i];
                    if (up_v[i]) begin
                        r[i]  <= up_r[i];
                        bw[i] <= up_b[i];
                    end
                end
            end
        end
    end
    assign in_ready  = !rst && ld[0];
    assign out_valid = v[STAGES-1];
    assign subOut    = r[STAGES-1];
    assign borrow    = bw[STAGES-1];
endmodule

// File: tb/tb_sub_pipe.sv
// tb_sub_pipe: directed self-checking bench for sub_pipe with WIDTH=4, STAGES=2.
module tb_sub_pipe;
    logic       clk = 0;
    logic       rst, in_valid, in_ready, abs_mode, out_valid, out_ready, borrow;
    logic [3:0] a, b;
    logic [4:0] sub_out, held;
    logic       stl;
    int         checks = 0, errors = 0, sent = 0, rcv = 0;
    logic [3:0] va [6] = '{4'd9, 4'd3, 4'd0, 4'd15, 4'd3, 4'd7};
    logic [3:0] vb [6] = '{4'd3, 4'd9, 4'd15, 4'd0, 4'd9, 4'd7};
    logic       vm [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [4:0] ex [6] = '{5'b00110, 5'b11010, 5'b10001, 5'b01111, 5'b00110, 5'b00000};
    logic       eb [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [4:0] es [8] = '{5'b11101, 5'b11110, 5'b11111, 5'b00000,
                           5'b00001, 5'b00010, 5'b00011, 5'b00100};

    always #5 clk = ~clk;

    sub_pipe #(.WIDTH(4), .STAGES(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .aIn(a), .bIn(b), .abs_mode(abs_mode), .out_valid(out_valid),
        .out_ready(out_ready), .subOut(sub_out), .borrow(borrow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        rst = 1; in_valid = 1; a = 9; b = 3; abs_mode = 0; out_ready = 1; stl = 0; held = '0;
        repeat (3) @(negedge clk);
        check("rst_vld", out_valid, 0);
        check("rst_sub", sub_out, 0);
        check("rst_brw", borrow, 0);
        check("rst_rdy", in_ready, 0);
        rst = 0; in_valid = 0;
        #1 check("rel_rdy", in_ready, 1);
        @(negedge clk);
        check("rel_vld", out_valid, 0);
        // basic and abs vectors, each expected exactly two cycles after acceptance
        for (int i = 0; i < 8; i++) begin
            if (i < 2) check("lat", out_valid, 0);
            else begin
                check("vld", out_valid, 1);
                check("sub", sub_out, ex[i-2]);
                check("brw", borrow, eb[i-2]);
            end
            in_valid = i < 6;
            if (i < 6) begin a = va[i]; b = vb[i]; abs_mode = vm[i]; end
            @(negedge clk);
        end
        check("drain", out_valid, 0);
        // stream of 8 with a 4-cycle stall
        for (int c = 0; c < 20; c++) begin
            out_ready = !(c >= 3 && c < 7);
            in_valid  = sent < 8;
            a = 4'(sent); b = 3; abs_mode = 0;
            #1;
            if (stl) begin
                check("hold_vld", out_valid, 1);
                check("hold_sub", sub_out, held);
            end
            if (c == 2) check("full_rdy", in_ready, 1);
            if (c == 6) begin
                check("stall_rdy", in_ready, 0);
                check("occ", sent - rcv, 2);
            end
            if (out_valid && out_ready) begin
                check("ord_sub", sub_out, es[rcv]);
                check("ord_brw", borrow, rcv < 3);
                rcv++;
            end
            stl  = out_valid && !out_ready;
            held = sub_out;
            if (in_valid && in_ready) sent++;
            @(negedge clk);
        end
        check("rcv", rcv, 8);
        check("sent", sent, 8);
        check("str_end", out_valid, 0);
        // bubble collapse with output stalled
        out_ready = 0; in_valid = 1; a = 5; b = 1;
        #1 check("bub_rdy0", in_ready, 1);
        @(negedge clk);
        in_valid = 0;
        #1 check("bub_rdy1", in_ready, 1);
        @(negedge clk);
        check("bub_vld", out_valid, 1);
        check("bub_sub", sub_out, 5'b00100);
        check("bub_rdy2", in_ready, 1);
        @(negedge clk);
        in_valid = 1; a = 2; b = 6;
        #1 check("bub_rdy3", in_ready, 1);
        @(negedge clk);
        in_valid = 0;
        #1 check("bub_full", in_ready, 0);
        check("bub_hold", sub_out, 5'b00100);
        out_ready = 1;
        #1 check("bub_pass", in_ready, 1);
        @(negedge clk);
        check("bub2_vld", out_valid, 1);
        check("bub2_sub", sub_out, 5'b11100);
        check("bub2_brw", borrow, 1);
        @(negedge clk);
        check("bub_end", out_valid, 0);
        // reset with two results in flight
        out_ready = 0; in_valid = 1; a = 8; b = 1;
        @(negedge clk);
        a = 1; b = 8;
        @(negedge clk);
        in_valid = 0;
        check("fl_vld", out_valid, 1);
        rst = 1;
        #1 check("fl_rdy", in_ready, 0);
        @(negedge clk);
        rst = 0; out_ready = 1;
        check("fl_rst_vld", out_valid, 0);
        check("fl_rst_sub", sub_out, 0);
        check("fl_rst_brw", borrow, 0);
        #1 check("fl_rel_rdy", in_ready, 1);
        repeat (4) begin
            @(negedge clk);
            check("fl_gone", out_valid, 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sub_pipe.md
SUB_PIPE -- requirements
Module: sub_pipe

Interface
REQ-001 Parameter WIDTH, default 4, operand width in bits; legal range 2..32.
REQ-002 Parameter STAGES, default 2, pipeline depth in register stages; legal range 1..4.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  operand pair on aIn/bIn/abs_mode valid this cycle.
REQ-006 in_ready  output  1  block accepts the operand pair this cycle.
REQ-007 aIn  input  WIDTH  minuend, unsigned.
REQ-008 bIn  input  WIDTH  subtrahend, unsigned.
REQ-009 abs_mode  input  1  1 = output |aIn-bIn|; 0 = output signed aIn-bIn; sampled with the operands.
REQ-010 out_valid  output  1  subOut/borrow hold a result.
REQ-011 out_ready  input  1  downstream consumes the result this cycle.
REQ-012 subOut  output  WIDTH+1  signed two's-complement result.
REQ-013 borrow  output  1  1 when aIn < bIn for this result, in both modes.

Function
REQ-014 An input transfer occurs on a cycle where in_valid=1 and in_ready=1; an output transfer occurs on a cycle where out_valid=1 and out_ready=1.
REQ-015 The result is exact: subOut = aIn - bIn computed in WIDTH+1 bits; no wrap or saturation, since range -(2^WIDTH-1)..(2^WIDTH-1) fits.
REQ-016 With abs_mode=1, subOut = |aIn-bIn|, always non-negative; borrow still reports aIn < bIn.
REQ-017 Each of the STAGES stages holds one valid bit plus payload; operands, abs_mode, result and borrow travel together.
REQ-018 A stage loads from its upstream when it is empty or when it transfers downstream in the same cycle.
REQ-019 The pipeline collapses bubbles: an empty stage accepts data even while later stages are stalled.
REQ-020 in_ready = stage 1 empty OR stage 1 advancing this cycle; in_ready is combinational from internal state and out_ready only, never from in_valid.
REQ-021 Latency with out_ready held 1: a pair accepted at rising edge N appears with out_valid=1 after edge N+STAGES-1, i.e. visible in the cycle following that edge (STAGES=1: visible the cycle after acceptance).
REQ-022 Throughput is one transfer per cycle with out_ready held 1; no bubbles are inserted.
REQ-023 While out_valid=1 and out_ready=0, subOut and borrow hold stable and no result is dropped or duplicated.
REQ-024 When full and stalled, in_ready=0; capacity is exactly STAGES results.
REQ-025 Full with simultaneous output and input transfer: the pipeline accepts the new pair, occupancy stays STAGES and in_ready stays 1.
REQ-026 Results leave in acceptance order.
REQ-027 When out_valid=0, subOut and borrow hold their last value; they carry no meaning.

Reset
REQ-028 With rst=1 at a rising edge, all stage valid bits clear; out_valid=0, subOut=0, borrow=0 the following cycle.
REQ-029 in_ready=0 while rst=1, and in_ready=1 the first cycle after rst deasserts.
REQ-030 Reset mid-operation discards all in-flight results; none appear after release.

Verification (WIDTH=4, STAGES=2)
REQ-031 Reset: hold rst=1 for 3 cycles with in_valid=1 -> out_valid=0, subOut=5'b00000, borrow=0, in_ready=0; after release in_ready=1, no output.
REQ-032 Basic: a=9,b=3 -> subOut=+6 (5'b00110), borrow=0; a=3,b=9 -> subOut=-6 (5'b11010), borrow=1; a=0,b=15 -> -15 (5'b10001); a=15,b=0 -> +15 (5'b01111); each appears 2 cycles after acceptance.
REQ-033 Abs mode: a=3,b=9,abs_mode=1 -> subOut=+6 (5'b00110), borrow=1; a=7,b=7 -> subOut=0, borrow=0.
REQ-034 Stream and stall: 8 back-to-back pairs with out_ready=1, then out_ready=0 for 4 cycles mid-stream -> in_ready falls after 2 more accepts, output holds stable, all 8 results emerge in order with none lost or duplicated.
REQ-035 Bubble collapse: accept one pair, leave it stalled at the output with out_ready=0, then idle one cycle -> second pair accepted and stage 1 fills; in_ready=0 only once both stages hold data.
REQ-036 Reset in flight: accept 2 pairs, assert rst for 1 cycle before either is consumed -> out_valid=0 after reset and neither result ever appears.
